cache_arbiter: RTL and testbench

//  Shares one line-wide physical-memory port between the icache (read-only) and dcache (read/write).

---
 rtl/cache_arb_pkg.sv | 8 +
 rtl/cache_arbiter.sv | 108 ++++++++++
 tb/tb_cache_arbiter.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/cache_arb_pkg.sv
// Shared types for the icache/dcache physical-memory arbiter.
package cache_arb_pkg;

  typedef enum logic [1:0] {ARB_IDLE, ARB_ICACHE, ARB_DCACHE} arb_state_t;

  typedef enum logic {CLIENT_I, CLIENT_D} client_t;

endpackage

// File: rtl/cache_arbiter.sv
// Shares one line-wide pmem port between icache (read-only) and dcache (read/write);
// one transaction at a time, round-robin on conflict, resp/rdata routed to the owner only.
module cache_arbiter
  import cache_arb_pkg::*;
#(
  parameter int unsigned s_offset = 5,
  parameter int unsigned s_line   = 8 * 2**s_offset
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       i_address,
  input  logic              i_read,
  output logic [s_line-1:0] i_rdata,
  output logic              i_resp,
  input  logic [31:0]       d_address,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [s_line-1:0] d_wdata,
  output logic [s_line-1:0] d_rdata,
  output logic              d_resp,
  output logic [31:0]       mem_address,
  output logic              mem_read,
  output logic              mem_write,
  output logic [s_line-1:0] mem_wdata,
  input  logic [s_line-1:0] mem_rdata,
  input  logic              mem_resp
);

  localparam logic [31:0] ADDR_MASK = {{(32 - s_offset){1'b1}}, {s_offset{1'b0}}};

  arb_state_t        state, next_state;
  client_t           last_grant;
  logic [31:0]       lat_addr;
  logic              lat_read, lat_write;
  logic [s_line-1:0] lat_wdata;
  logic              d_req, i_req;

  assign d_req = d_read | d_write;
  assign i_req = i_read;

  always_comb begin
    next_state = state;
    unique case (state)
      ARB_IDLE: begin
        // On a tie the client that was not granted last wins.
        if (d_req && (!i_req || last_grant == CLIENT_I)) next_state = ARB_DCACHE;
        else if (i_req)                                 next_state = ARB_ICACHE;
      end
      ARB_ICACHE, ARB_DCACHE: begin
        if (mem_resp) next_state = ARB_IDLE;
      end
      default: next_state = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= ARB_IDLE;
      last_grant <= CLIENT_I;
      lat_addr   <= '0;
      lat_read   <= 1'b0;
      lat_write  <= 1'b0;
      lat_wdata  <= '0;
    end else begin
      state <= next_state;
      if (state == ARB_IDLE && next_state == ARB_DCACHE) begin
        last_grant <= CLIENT_D;
        lat_addr   <= d_address & ADDR_MASK;
        // Illegal read+write from dcache resolves to the write.
        lat_write  <= d_write;
        lat_read   <= d_read & ~d_write;
        lat_wdata  <= d_wdata;
      end else if (state == ARB_IDLE && next_state == ARB_ICACHE) begin
        last_grant <= CLIENT_I;
        lat_addr   <= i_address & ADDR_MASK;
        lat_write  <= 1'b0;
        lat_read   <= 1'b1;
        lat_wdata  <= '0;
      end
    end
  end

  always_comb begin
    mem_address = '0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    mem_wdata   = '0;
    i_rdata     = '0;
    i_resp      = 1'b0;
    d_rdata     = '0;
    d_resp      = 1'b0;
    if (state != ARB_IDLE) begin
      mem_address = lat_addr;
      mem_read    = lat_read;
      mem_write   = lat_write;
      mem_wdata   = lat_wdata;
    end
    if (state == ARB_ICACHE) begin
      i_rdata = mem_rdata;
      i_resp  = mem_resp;
    end
    if (state == ARB_DCACHE) begin
      d_rdata = mem_rdata;
      d_resp  = mem_resp;
    end
  end

endmodule

// File: tb/tb_cache_arbiter.sv
// Self-checking bench for cache_arbiter: directed scenarios plus randomized traffic
// against a transaction-level reference model.
module tb_cache_arbiter;

  localparam int unsigned S_OFFSET = 5;
  localparam int unsigned S_LINE   = 256;

  logic              clk = 1'b0;
  logic              rst;
  logic [31:0]       i_address, d_address, mem_address;
  logic              i_read, d_read, d_write, mem_read, mem_write, mem_resp;
  logic              i_resp, d_resp;
  logic [S_LINE-1:0] i_rdata, d_rdata, d_wdata, mem_wdata, mem_rdata;

  cache_arbiter #(.s_offset(S_OFFSET), .s_line(S_LINE)) dut (
    .clk(clk), .rst(rst),
    .i_address(i_address), .i_read(i_read), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_address(d_address), .d_read(d_read), .d_write(d_write), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_resp(d_resp),
    .mem_address(mem_address), .mem_read(mem_read), .mem_write(mem_write),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  task automatic check(input string tag, input logic [S_LINE-1:0] got, input logic [S_LINE-1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Reference model: at most one outstanding line transaction, owned by a client.
  bit              m_busy;
  bit              m_owner_d;
  bit              m_prefer_d;
  bit              m_wr;
  logic [31:0]     m_addr;
  logic [S_LINE-1:0] m_wdata;

  task automatic model_reset();
    m_busy = 0; m_owner_d = 0; m_prefer_d = 1; m_wr = 0; m_addr = '0; m_wdata = '0;
  endtask

  task automatic model_edge();
    bit want_d, want_i;
    if (!rst) begin
      model_reset();
    end else if (m_busy) begin
      if (mem_resp) m_busy = 0;
    end else begin
      want_d = d_read | d_write;
      want_i = i_read;
      if (want_d && (!want_i || m_prefer_d)) begin
        m_busy = 1; m_owner_d = 1; m_prefer_d = 0;
        m_addr = {d_address[31:S_OFFSET], {S_OFFSET{1'b0}}};
        m_wr = d_write; m_wdata = d_wdata;
      end else if (want_i) begin
        m_busy = 1; m_owner_d = 0; m_prefer_d = 1;
        m_addr = {i_address[31:S_OFFSET], {S_OFFSET{1'b0}}};
        m_wr = 0; m_wdata = '0;
      end
    end
  endtask

  task automatic settle();
    bit own_i, own_d;
    #1;
    own_i = m_busy && !m_owner_d;
    own_d = m_busy && m_owner_d;
    check("mem_read",    mem_read,    m_busy && !m_wr);
    check("mem_write",   mem_write,   m_busy && m_wr);
    check("mem_address", mem_address, m_busy ? m_addr : 32'h0);
    check("mem_wdata",   mem_wdata,   m_busy ? m_wdata : '0);
    check("i_resp",      i_resp,      own_i && mem_resp);
    check("d_resp",      d_resp,      own_d && mem_resp);
    check("i_rdata",     i_rdata,     own_i ? mem_rdata : '0);
    check("d_rdata",     d_rdata,     own_d ? mem_rdata : '0);
  endtask

  task automatic advance();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic quiet();
    i_read = 0; d_read = 0; d_write = 0; mem_resp = 0;
  endtask

  task automatic do_reset(input int unsigned cycles);
    rst = 0;
    for (int unsigned k = 0; k < cycles; k++) begin settle(); advance(); end
    rst = 1;
  endtask

  logic [S_LINE-1:0] line_a5, line_3c, line_w;
  int unsigned resp_count;

  initial begin
    line_a5 = {32{8'hA5}};
    line_3c = {32{8'h3C}};
    line_w  = {8{32'hDEAD_BEEF}};
    rst = 0; quiet();
    i_address = '0; d_address = '0; d_wdata = '0; mem_rdata = '0;
    model_reset();
    @(negedge clk);
    do_reset(2);
    check("reset_mem_read", mem_read, 1'b0);

    // Test 1: reset mid dcache write abandons it.
    d_write = 1; d_address = 32'h0000_4444; d_wdata = line_w;
    settle(); advance();
    settle(); check("t1_write_up", mem_write, 1'b1); advance();
    quiet();
    do_reset(2);
    settle();
    check("t1_write_dn", mem_write, 1'b0);
    check("t1_no_dresp", d_resp, 1'b0);
    advance();

    // Test 2: lone icache read.
    i_read = 1; i_address = 32'h0000_1234;
    settle(); advance();
    i_read = 0;
    settle();
    check("t2_mem_read", mem_read, 1'b1);
    check("t2_addr", mem_address, 32'h0000_1220);
    advance();
    mem_resp = 1; mem_rdata = line_a5;
    settle();
    check("t2_i_resp", i_resp, 1'b1);
    check("t2_i_rdata", i_rdata, line_a5);
    check("t2_d_resp", d_resp, 1'b0);
    advance();
    quiet(); settle(); advance();

    // Test 3: tie after reset -> dcache, then icache, then tie -> dcache.
    do_reset(1);
    i_read = 1; i_address = 32'h0000_2000;
    d_write = 1; d_address = 32'h0000_3010; d_wdata = line_w;
    settle(); advance();
    settle();
    check("t3_d_first", mem_write, 1'b1);
    check("t3_wdata", mem_wdata, line_w);
    check("t3_addr", mem_address, 32'h0000_3000);
    advance();
    mem_resp = 1; mem_rdata = line_3c;
    settle(); check("t3_d_resp", d_resp, 1'b1); check("t3_i_quiet", i_resp, 1'b0);
    advance();
    mem_resp = 0; d_write = 0;
    settle(); check("t3_turnaround", mem_read | mem_write, 1'b0); advance();
    settle(); check("t3_i_second", mem_read, 1'b1); check("t3_i_addr", mem_address, 32'h0000_2000);
    advance();
    mem_resp = 1; settle(); check("t3_i_resp", i_resp, 1'b1); advance();
    mem_resp = 0; d_write = 1; d_address = 32'h0000_5000;
    settle(); advance();
    settle(); check("t3_rr_d", mem_write, 1'b1); check("t3_rr_i_wait", mem_read, 1'b0);
    advance();
    mem_resp = 1; settle(); advance();
    quiet(); settle(); advance();

    // Test 4: illegal read+write -> write wins.
    d_read = 1; d_write = 1; d_address = 32'h8000_0040;
    settle(); advance();
    d_read = 0; d_write = 0;
    settle();
    check("t4_write", mem_write, 1'b1);
    check("t4_read", mem_read, 1'b0);
    check("t4_addr", mem_address, 32'h8000_0040);
    advance();
    mem_resp = 1; settle(); advance();
    quiet();

    // Test 5: mem_resp in IDLE is ignored.
    settle(); advance();
    mem_resp = 1;
    settle();
    check("t5_i_resp", i_resp, 1'b0);
    check("t5_d_resp", d_resp, 1'b0);
    advance();
    mem_resp = 0; settle();
    check("t5_still_idle", mem_read | mem_write, 1'b0);
    advance();

    // Test 6: request dropped early; write held until late resp.
    d_write = 1; d_address = 32'h0000_0100; d_wdata = line_w;
    settle(); advance();
    d_write = 0;
    resp_count = 0;
    for (int unsigned k = 0; k < 10; k++) begin
      settle(); check("t6_held", mem_write, 1'b1);
      resp_count += d_resp;
      advance();
    end
    mem_resp = 1; settle(); resp_count += d_resp; advance();
    mem_resp = 0; settle(); resp_count += d_resp; advance();
    check("t6_resp_once", resp_count, 1);

    // Randomized traffic.
    for (int unsigned k = 0; k < 4000; k++) begin
      rst       = ($urandom_range(0, 199) != 0);
      i_read    = ($urandom_range(0, 2) == 0);
      d_read    = ($urandom_range(0, 3) == 0);
      d_write   = ($urandom_range(0, 3) == 0);
      i_address = $urandom;
      d_address = $urandom;
      d_wdata   = {8{$urandom}};
      mem_rdata = {8{$urandom}};
      mem_resp  = ($urandom_range(0, 3) == 0);
      settle();
      advance();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
